// File: rtl/wb_arb_pkg.sv
// Shared widths and the buffered MDU result entry for the regfile write arbiter.
package wb_arb_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
        logic                  killed;
    } fifo_entry_t;
endpackage

// File: rtl/wb_write_arbiter_if.sv
// Write-back / MDU request and regfile write-port bundle for wb_write_arbiter.
interface wb_write_arbiter_if;
    import wb_arb_pkg::*;

    logic                  iwb_we;
    logic [REG_ADDR_W-1:0] iwb_addr;
    logic [DATA_W-1:0]     iwb_data;
    logic                  imdu_valid;
    logic [REG_ADDR_W-1:0] imdu_addr;
    logic [DATA_W-1:0]     imdu_data;
    logic                  omdu_ready;
    logic                  orf_we;
    logic [REG_ADDR_W-1:0] orf_addr;
    logic [DATA_W-1:0]     orf_data;
    logic                  ostall;
    logic [1:0]            obuf_count;

    modport slave (
        input  iwb_we, iwb_addr, iwb_data, imdu_valid, imdu_addr, imdu_data,
        output omdu_ready, orf_we, orf_addr, orf_data, ostall, obuf_count
    );

    modport master (
        output iwb_we, iwb_addr, iwb_data, imdu_valid, imdu_addr, imdu_data,
        input  omdu_ready, orf_we, orf_addr, orf_data, ostall, obuf_count
    );
endinterface

// File: rtl/wb_mdu_fifo.sv
// Two-entry in-order FIFO of MDU results; head lives in slot 0.
// A squash request marks every stored entry matching squash_addr as killed.
module wb_mdu_fifo
    import wb_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  fifo_entry_t           push_entry,
    input  logic                  pop,
    input  logic                  squash,
    input  logic [REG_ADDR_W-1:0] squash_addr,
    output fifo_entry_t           head,
    output logic [1:0]            count
);
    fifo_entry_t e0, e1, m0, m1;
    logic [1:0]  occ;

    always_comb begin
        m0 = e0;
        m1 = e1;
        if (squash && (e0.addr == squash_addr)) m0.killed = 1'b1;
        if (squash && (e1.addr == squash_addr)) m1.killed = 1'b1;
    end

    // Occupancy after this cycle's pop decides which slot a push lands in.
    assign occ  = count - {1'b0, pop};
    assign head = e0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= 2'd0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        e0 <= m0;
        e1 <= m1;
        if (pop) e0 <= m1;
        if (push) begin
            if (occ == 2'd0) e0 <= push_entry;
            else             e1 <= push_entry;
        end
    end
endmodule

// File: rtl/wb_write_arbiter.sv
// Regfile write-port arbiter: WB requests win, MDU results wait in a 2-entry FIFO.
// Optional WAW squash of stale buffered MDU results: define WB_WAW_SQUASH_EN.
module wb_write_arbiter
    import wb_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rstn,
    wb_write_arbiter_if.slave bus
);
    localparam int               AGE_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_LIMIT);
    localparam logic [AGE_W-1:0] AGE_WARN = AGE_W'(STARVE_LIMIT - 1);

    fifo_entry_t           head, push_entry;
    logic [1:0]            count, count_nxt;
    logic [AGE_W-1:0]      age, age_nxt;
    logic                  ready, wb_win, mdu_acc, head_vld, pop, head_wr;
    logic                  bypass, push, squash;
    logic                  rf_we, stall;
    logic [REG_ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0]     rf_data;

    function automatic logic [AGE_W-1:0] sat_age(input logic [AGE_W-1:0] a);
        return (a >= AGE_MAX) ? AGE_MAX : a + 1'b1;
    endfunction

    assign ready    = (count != 2'd2) && rstn;
    assign wb_win   = bus.iwb_we && (bus.iwb_addr != '0);
    assign mdu_acc  = bus.imdu_valid && ready && (bus.imdu_addr != '0);
    assign head_vld = (count != 2'd0);
    // Killed heads drain even under a WB write since they need no write port.
    assign pop      = head_vld && (head.killed || !wb_win);
    assign head_wr  = pop && !head.killed;
    // An idle port with an empty FIFO writes the MDU result straight through.
    assign bypass   = mdu_acc && !head_vld && !wb_win;
    assign push     = mdu_acc && !bypass;

    always_comb begin
        push_entry        = '0;
        push_entry.addr   = bus.imdu_addr;
        push_entry.data   = bus.imdu_data;
        push_entry.killed = 1'b0;
    end

`ifdef WB_WAW_SQUASH_EN
    assign squash = wb_win;
`else
    assign squash = 1'b0;
`endif

    assign count_nxt = count + {1'b0, push} - {1'b0, pop};
    assign age_nxt   = (!head_vld || pop) ? '0 : sat_age(age);

    wb_mdu_fifo u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .squash      (squash),
        .squash_addr (bus.iwb_addr),
        .head        (head),
        .count       (count)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
            stall   <= 1'b0;
            age     <= '0;
        end else begin
            rf_we <= wb_win || head_wr || bypass;
            if (wb_win) begin
                rf_addr <= bus.iwb_addr;
                rf_data <= bus.iwb_data;
            end else if (head_wr) begin
                rf_addr <= head.addr;
                rf_data <= head.data;
            end else if (bypass) begin
                rf_addr <= bus.imdu_addr;
                rf_data <= bus.imdu_data;
            end
            stall <= (count_nxt == 2'd2) || (age_nxt >= AGE_WARN);
            age   <= age_nxt;
        end
    end

    assign bus.omdu_ready = ready;
    assign bus.orf_we     = rf_we;
    assign bus.orf_addr   = rf_addr;
    assign bus.orf_data   = rf_data;
    assign bus.ostall     = stall;
    assign bus.obuf_count = count;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: expected regfile writes are queued at drive time.
module tb_wb_write_arbiter;
    import wb_arb_pkg::*;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    wb_write_arbiter_if bus();

    wb_write_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    wr_t exp_q[$];
    wr_t wb_q[$];
    wr_t mdu_q[$];
    wr_t mon_got, mon_exp;
    int  n_total = 0;
    int  n_bad   = 0;
    bit  rnd_mode = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every observed write is matched against the scoreboard in order.
    always @(negedge clk) begin
        if (bus.orf_we === 1'b1) begin
            mon_got = '{addr: bus.orf_addr, data: bus.orf_data};
            if (!rnd_mode) begin
                if (exp_q.size() == 0) check_val("spurious_we", 64'(bus.orf_we), 64'd0);
                else begin
                    mon_exp = exp_q.pop_front();
                    check_val("wr", {27'd0, mon_got}, {27'd0, mon_exp});
                end
            end else if (mon_got.data[31]) begin
                if (wb_q.size() == 0) check_val("spurious_wb", 64'(bus.orf_we), 64'd0);
                else begin
                    mon_exp = wb_q.pop_front();
                    check_val("rnd_wb_wr", {27'd0, mon_got}, {27'd0, mon_exp});
                end
            end else begin
                if (mdu_q.size() == 0) check_val("spurious_mdu", 64'(bus.orf_we), 64'd0);
                else begin
                    mon_exp = mdu_q.pop_front();
                    check_val("rnd_mdu_wr", {27'd0, mon_got}, {27'd0, mon_exp});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.iwb_we     = 1'b0;
        bus.iwb_addr   = '0;
        bus.iwb_data   = '0;
        bus.imdu_valid = 1'b0;
        bus.imdu_addr  = '0;
        bus.imdu_data  = '0;
    endtask

    task automatic drive_wb(input logic [4:0] a, input logic [31:0] d);
        bus.iwb_we   = 1'b1;
        bus.iwb_addr = a;
        bus.iwb_data = d;
        if (a != 5'd0) begin
            if (rnd_mode) wb_q.push_back('{addr: a, data: d});
            else          exp_q.push_back('{addr: a, data: d});
        end
    endtask

    task automatic drive_mdu(input logic [4:0] a, input logic [31:0] d);
        check_val("mdu_ready", 64'(bus.omdu_ready), 64'd1);
        bus.imdu_valid = 1'b1;
        bus.imdu_addr  = a;
        bus.imdu_data  = d;
        if (rnd_mode && a != 5'd0) mdu_q.push_back('{addr: a, data: d});
    endtask

    initial begin
        idle();
        rstn = 1'b0;
        bus.imdu_valid = 1'b1;
        bus.imdu_addr  = 5'd8;
        bus.imdu_data  = 32'h1234;
        repeat (3) begin
            tick();
            check_val("rst_ready", 64'(bus.omdu_ready), 64'd0);
            check_val("rst_we", 64'(bus.orf_we), 64'd0);
            check_val("rst_count", 64'(bus.obuf_count), 64'd0);
        end
        check_val("rst_addr", 64'(bus.orf_addr), 64'd0);
        check_val("rst_data", 64'(bus.orf_data), 64'd0);
        check_val("rst_stall", 64'(bus.ostall), 64'd0);
        rstn = 1'b1;
        idle();
        tick();

        // lone MDU result, idle WB
        drive_mdu(5'd8, 32'h1234);
        exp_q.push_back('{addr: 5'd8, data: 32'h1234});
        tick();
        idle();
        check_val("solo_we", 64'(bus.orf_we), 64'd1);
        check_val("solo_count", 64'(bus.obuf_count), 64'd0);
        tick();
        check_val("solo_we_off", 64'(bus.orf_we), 64'd0);

        // WB and MDU on the same edge
        drive_wb(5'd3, 32'hAAAA);
        drive_mdu(5'd9, 32'h5555);
        exp_q.push_back('{addr: 5'd9, data: 32'h5555});
        tick();
        idle();
        check_val("same_first", 64'(bus.orf_addr), 64'd3);
        check_val("same_count", 64'(bus.obuf_count), 64'd1);
        tick();
        check_val("same_second", 64'(bus.orf_addr), 64'd9);
        check_val("same_count0", 64'(bus.obuf_count), 64'd0);
        tick();

        // WB every cycle fills the FIFO
        drive_wb(5'd1, 32'h11);
        drive_mdu(5'd5, 32'h55);
        tick();
        drive_wb(5'd2, 32'h22);
        drive_mdu(5'd6, 32'h66);
        tick();
        check_val("full_count", 64'(bus.obuf_count), 64'd2);
        check_val("full_ready", 64'(bus.omdu_ready), 64'd0);
        check_val("full_stall", 64'(bus.ostall), 64'd1);
        idle();
        drive_wb(5'd4, 32'h44);
        exp_q.push_back('{addr: 5'd5, data: 32'h55});
        exp_q.push_back('{addr: 5'd6, data: 32'h66});
        tick();
        check_val("stall_wb_honoured", 64'(bus.orf_addr), 64'd4);
        idle();
        tick();
        check_val("drain_r5", 64'(bus.orf_addr), 64'd5);
        check_val("drain_count1", 64'(bus.obuf_count), 64'd1);
        tick();
        check_val("drain_r6", 64'(bus.orf_addr), 64'd6);
        check_val("drain_count0", 64'(bus.obuf_count), 64'd0);
        tick();

        // starvation: one buffered entry, WB busy four cycles
        drive_wb(5'd10, 32'hA0);
        drive_mdu(5'd11, 32'hB0);
        tick();
        check_val("starve_stall0", 64'(bus.ostall), 64'd0);
        for (int k = 1; k <= 3; k++) begin
            idle();
            drive_wb(5'd10, 32'hA0 + 32'(k));
            tick();
            check_val("starve_stall", 64'(bus.ostall), (k == 3) ? 64'd1 : 64'd0);
        end
        idle();
        exp_q.push_back('{addr: 5'd11, data: 32'hB0});
        tick();
        check_val("starve_pop_addr", 64'(bus.orf_addr), 64'd11);
        check_val("starve_stall_off", 64'(bus.ostall), 64'd0);
        tick();

        // WAW: buffered r7 then WB r7
        drive_wb(5'd1, 32'h100);
        drive_mdu(5'd7, 32'h1);
        tick();
        idle();
        drive_wb(5'd7, 32'h2);
        tick();
        idle();
`ifndef WB_WAW_SQUASH_EN
        exp_q.push_back('{addr: 5'd7, data: 32'h1});
`endif
        tick();
        check_val("waw_count", 64'(bus.obuf_count), 64'd0);
`ifdef WB_WAW_SQUASH_EN
        check_val("waw_we", 64'(bus.orf_we), 64'd0);
`else
        check_val("waw_we", 64'(bus.orf_we), 64'd1);
`endif
        tick();

        // address 0 is discarded on both paths
        drive_wb(5'd0, 32'hDEAD);
        drive_mdu(5'd0, 32'hBEEF);
        tick();
        check_val("zero_we", 64'(bus.orf_we), 64'd0);
        check_val("zero_count", 64'(bus.obuf_count), 64'd0);
        idle();
        drive_wb(5'd0, 32'hDEAD);
        drive_mdu(5'd12, 32'hC);
        exp_q.push_back('{addr: 5'd12, data: 32'hC});
        tick();
        check_val("zero_wb_mdu", 64'(bus.orf_addr), 64'd12);
        idle();
        tick();

        // random mix; WB data tagged with bit 31, disjoint register ranges
        rnd_mode = 1'b1;
        for (int c = 0; c < 80; c++) begin
            logic [4:0] ma;
            idle();
            if ($urandom_range(0, 2) == 0)
                drive_wb(5'($urandom_range(0, 15)), {1'b1, 31'($urandom)});
            if (bus.omdu_ready && ($urandom_range(0, 1) == 1)) begin
                ma = 5'($urandom_range(15, 31));
                if (ma == 5'd15) ma = 5'd0;
                drive_mdu(ma, {1'b0, 31'($urandom)});
            end
            tick();
        end
        idle();
        repeat (8) tick();
        check_val("pending", 64'(exp_q.size() + wb_q.size() + mdu_q.size()), 64'd0);
        check_val("final_count", 64'(bus.obuf_count), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
